// File: rtl/xoodyak_aead_core.sv
// Iterative Xoodyak keyed AEAD (Cyclist over Xoodoo): 128b key/nonce/AD, one 192b text block, 128b tag.
// Define XOODYAK_TWO_ROUND_EN to compute two rounds per cycle (24-cycle latency instead of 48).
module xoodyak_aead_core #(
  parameter int ROUNDS = 12
) (
  input  logic         eph1,
  input  logic         reset,
  input  logic         start,
  input  logic [191:0] textin,
  input  logic [127:0] nonce,
  input  logic [127:0] assodata,
  input  logic [127:0] key,
  input  logic         opmode,
  output logic [127:0] authdata,
  output logic [191:0] textout,
  output logic         encdone
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PERM = 1'b1;
`ifdef XOODYAK_TWO_ROUND_EN
  localparam int RSTEP = 2;
`else
  localparam int RSTEP = 1;
`endif
  localparam logic [3:0] RSTEP4  = 4'(RSTEP);
  localparam logic [3:0] LAST_RD = 4'(ROUNDS - RSTEP);
  localparam logic [3:0] RC_BASE = 4'(12 - ROUNDS);

  logic [0:0]   fsm_r;
  logic [1:0]   phase_r;
  logic [3:0]   round_r;
  logic [383:0] state_r;
  logic [127:0] nonce_r, ad_r, authdata_r;
  logic [191:0] text_r, textout_r;
  logic         opmode_r, encdone_r;
  logic [3:0]   rc_idx_s;
  logic [383:0] perm1_s, perm_s;
  logic [191:0] ptext_s;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] round_const(input logic [3:0] idx);
    case (idx)
      4'd0:    return 32'h0000_0058;
      4'd1:    return 32'h0000_0038;
      4'd2:    return 32'h0000_03C0;
      4'd3:    return 32'h0000_00D0;
      4'd4:    return 32'h0000_0120;
      4'd5:    return 32'h0000_0014;
      4'd6:    return 32'h0000_0060;
      4'd7:    return 32'h0000_002C;
      4'd8:    return 32'h0000_0380;
      4'd9:    return 32'h0000_00F0;
      4'd10:   return 32'h0000_01A0;
      4'd11:   return 32'h0000_0012;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // State is kept in string byte order: byte i at bits [8i+7:8i], so lane i is bits [32i+31:32i].
  function automatic logic [383:0] xoodoo_round(input logic [383:0] s, input logic [31:0] rc);
    logic [127:0] a0, a1, a2, p, e, w1, w2, c0, c1, c2, o1, o2;
    a0 = s[127:0];
    a1 = s[255:128];
    a2 = s[383:256];
    p  = a0 ^ a1 ^ a2;
    for (int x = 0; x < 4; x++) begin
      e[32*x +: 32] = rotl(p[32*((x+3)%4) +: 32], 5) ^ rotl(p[32*((x+3)%4) +: 32], 14);
    end
    a0 = a0 ^ e;
    a1 = a1 ^ e;
    a2 = a2 ^ e;
    for (int x = 0; x < 4; x++) begin
      w1[32*x +: 32] = a1[32*((x+3)%4) +: 32];
      w2[32*x +: 32] = rotl(a2[32*x +: 32], 11);
    end
    a0[31:0] = a0[31:0] ^ rc;
    c0 = a0 ^ (~w1 & w2);
    c1 = w1 ^ (~w2 & a0);
    c2 = w2 ^ (~a0 & w1);
    for (int x = 0; x < 4; x++) begin
      o1[32*x +: 32] = rotl(c1[32*x +: 32], 1);
      o2[32*x +: 32] = rotl(c2[32*((x+2)%4) +: 32], 8);
    end
    return {o2, o1, c0};
  endfunction

  function automatic logic [127:0] rev16(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [191:0] rev24(input logic [191:0] v);
    logic [191:0] r;
    for (int i = 0; i < 24; i++) r[8*i +: 8] = v[191-8*i -: 8];
    return r;
  endfunction

  assign rc_idx_s = RC_BASE + round_r;

  // Permutation datapath: one or two rounds on the current state
  always_comb begin
    perm1_s = xoodoo_round(state_r, round_const(rc_idx_s));
`ifdef XOODYAK_TWO_ROUND_EN
    perm_s  = xoodoo_round(perm1_s, round_const(rc_idx_s + 4'd1));
`else
    perm_s  = perm1_s;
`endif
  end

  // Plaintext block absorbed after the crypt step (Y ^ C when decrypting)
  always_comb begin
    ptext_s = rev24(text_r);
    if (opmode_r) begin
      ptext_s = perm_s[191:0] ^ rev24(text_r);
    end else begin
      ptext_s = rev24(text_r);
    end
  end

  // Control FSM, Cyclist state and registered outputs; Cu of the next phase is folded into byte 47
  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      fsm_r      <= ST_IDLE;
      phase_r    <= 2'd0;
      round_r    <= 4'd0;
      state_r    <= 384'd0;
      nonce_r    <= 128'd0;
      ad_r       <= 128'd0;
      text_r     <= 192'd0;
      opmode_r   <= 1'b0;
      authdata_r <= 128'd0;
      textout_r  <= 192'd0;
      encdone_r  <= 1'b0;
    end else begin
      encdone_r <= 1'b0;
      case (fsm_r)
        ST_IDLE: begin
          if (start) begin
            state_r  <= {8'h02, 232'd0, 8'h01, 8'h00, rev16(key)};
            nonce_r  <= nonce;
            ad_r     <= assodata;
            text_r   <= textin;
            opmode_r <= opmode;
            phase_r  <= 2'd0;
            round_r  <= 4'd0;
            fsm_r    <= ST_PERM;
          end
        end
        ST_PERM: begin
          if (round_r != LAST_RD) begin
            state_r <= perm_s;
            round_r <= round_r + RSTEP4;
          end else begin
            round_r <= 4'd0;
            phase_r <= phase_r + 2'd1;
            case (phase_r)
              2'd0: state_r <= perm_s ^ {8'h03, 240'd0, 8'h01, rev16(nonce_r)};
              2'd1: state_r <= perm_s ^ {8'h83, 240'd0, 8'h01, rev16(ad_r)};
              2'd2: begin
                textout_r <= rev24(perm_s[191:0]) ^ text_r;
                state_r   <= perm_s ^ {8'h40, 176'd0, 8'h01, ptext_s};
              end
              2'd3: begin
                authdata_r <= rev16(perm_s[127:0]);
                encdone_r  <= 1'b1;
                state_r    <= perm_s;
                fsm_r      <= ST_IDLE;
              end
              default: fsm_r <= ST_IDLE;
            endcase
          end
        end
        default: fsm_r <= ST_IDLE;
      endcase
    end
  end

  assign authdata = authdata_r;
  assign textout  = textout_r;
  assign encdone  = encdone_r;

endmodule

// File: tb/tb_xoodyak_aead_core.sv
// Directed bench for xoodyak_aead_core: a lane-array Xoodyak model supplies expected text/tag values.
`timescale 1ns/1ps
module tb_xoodyak_aead_core;

  logic         eph1 = 1'b0;
  logic         reset, start, opmode;
  logic [191:0] textin;
  logic [127:0] nonce, assodata, key;
  logic [127:0] authdata;
  logic [191:0] textout;
  logic         encdone;

`ifdef XOODYAK_TWO_ROUND_EN
  localparam int LAT = 24;
`else
  localparam int LAT = 48;
`endif
  localparam logic [127:0] KEY_A   = 128'h303132333435363738393a3b3c3d3e3f;
  localparam logic [127:0] NONCE_A = 128'h4142434445464748494a4b4c4d4e4f50;
  localparam logic [127:0] AD_A    = 128'h6162636465666768696a6b6c6d6e6f70;
  localparam logic [191:0] PT_A    = 192'h4142434445464748494a4b4c4d4e4f505152535455565758;
  localparam logic [31:0]  RC_TAB [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                                           32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

  int check_cnt = 0;
  int fail_cnt  = 0;
  logic [31:0] mst [12];

  xoodyak_aead_core dut (
    .eph1(eph1), .reset(reset), .start(start), .textin(textin), .nonce(nonce),
    .assodata(assodata), .key(key), .opmode(opmode), .authdata(authdata),
    .textout(textout), .encdone(encdone)
  );

  always #5 eph1 = ~eph1;

  task automatic check_val(input string name, input logic [191:0] got, input logic [191:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  task automatic xor_byte(input int i, input logic [7:0] v);
    mst[i/4][8*(i%4) +: 8] = mst[i/4][8*(i%4) +: 8] ^ v;
  endtask

  function automatic logic [7:0] get_byte(input int i);
    return mst[i/4][8*(i%4) +: 8];
  endfunction

  task automatic model_perm();
    logic [31:0] b [12];
    logic [31:0] p [4];
    logic [31:0] e [4];
    for (int r = 0; r < 12; r++) begin
      for (int x = 0; x < 4; x++) p[x] = mst[x] ^ mst[x+4] ^ mst[x+8];
      for (int x = 0; x < 4; x++) e[x] = rol(p[(x+3)%4], 5) ^ rol(p[(x+3)%4], 14);
      for (int i = 0; i < 12; i++) mst[i] = mst[i] ^ e[i%4];
      for (int x = 0; x < 4; x++) begin
        b[x]   = mst[x];
        b[x+4] = mst[4+(x+3)%4];
        b[x+8] = rol(mst[x+8], 11);
      end
      b[0] = b[0] ^ RC_TAB[r];
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++)
          mst[x+4*y] = b[x+4*y] ^ (~b[x+4*((y+1)%3)] & b[x+4*((y+2)%3)]);
      for (int x = 0; x < 4; x++) begin
        b[x]   = mst[x];
        b[x+4] = rol(mst[x+4], 1);
        b[x+8] = rol(mst[8+(x+2)%4], 8);
      end
      for (int i = 0; i < 12; i++) mst[i] = b[i];
    end
  endtask

  task automatic absorb16(input logic [127:0] v, input logic [7:0] cd);
    for (int i = 0; i < 16; i++) xor_byte(i, v[127-8*i -: 8]);
    xor_byte(16, 8'h01);
    xor_byte(47, cd);
  endtask

  task automatic model_run(input logic [127:0] k, input logic [127:0] n, input logic [127:0] ad,
                           input logic [191:0] t, input logic dec,
                           output logic [191:0] tout, output logic [127:0] tag);
    logic [7:0] c;
    for (int i = 0; i < 12; i++) mst[i] = 32'd0;
    for (int i = 0; i < 16; i++) xor_byte(i, k[127-8*i -: 8]);
    xor_byte(17, 8'h01);
    xor_byte(47, 8'h02);
    model_perm();
    absorb16(n, 8'h03);
    model_perm();
    absorb16(ad, 8'h03);
    xor_byte(47, 8'h80);
    model_perm();
    for (int i = 0; i < 24; i++) begin
      c = get_byte(i) ^ t[191-8*i -: 8];
      tout[191-8*i -: 8] = c;
      xor_byte(i, dec ? c : t[191-8*i -: 8]);
    end
    xor_byte(24, 8'h01);
    xor_byte(47, 8'h40);
    model_perm();
    for (int i = 0; i < 16; i++) tag[127-8*i -: 8] = get_byte(i);
  endtask

  task automatic drive(input logic [127:0] k, input logic [127:0] n, input logic [127:0] ad,
                       input logic [191:0] t, input logic dec);
    key = k; nonce = n; assodata = ad; textin = t; opmode = dec;
  endtask

  task automatic start_now();
    start = 1'b1;
    @(posedge eph1); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int already, output int lat);
    lat = -1;
    for (int n = already + 1; n <= 200; n++) begin
      @(posedge eph1); #1;
      if (encdone) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge eph1); #1;
      if (encdone) pulses++;
    end
  endtask

  task automatic run_op(input string name, input logic [127:0] k, input logic [127:0] n,
                        input logic [127:0] ad, input logic [191:0] t, input logic dec,
                        input bit immediate);
    logic [191:0] mt;
    logic [127:0] mg;
    int lat;
    model_run(k, n, ad, t, dec, mt, mg);
    drive(k, n, ad, t, dec);
    if (!immediate) @(negedge eph1);
    start_now();
    wait_done(0, lat);
    check_val({name, "_latency"}, 192'(lat), 192'(LAT));
    check_val({name, "_textout"}, textout, mt);
    check_val({name, "_authdata"}, {64'd0, authdata}, {64'd0, mg});
  endtask

  initial begin
    logic [191:0] exp_ct;
    logic [127:0] exp_tag;
    int lat;
    int pulses;

    reset = 1'b1; start = 1'b0;
    drive(128'd0, 128'd0, 128'd0, 192'd0, 1'b0);
    repeat (2) @(posedge eph1);
    @(negedge eph1) reset = 1'b0;
    #1;
    check_val("rst_authdata", {64'd0, authdata}, 192'd0);
    check_val("rst_textout", textout, 192'd0);
    check_val("rst_encdone", {191'd0, encdone}, 192'd0);
    count_pulses(10, pulses);
    check_val("idle_no_done", 192'(pulses), 192'd0);

    // Encrypt the reference strings, then check the pulse is one cycle wide
    model_run(KEY_A, NONCE_A, AD_A, PT_A, 1'b0, exp_ct, exp_tag);
    run_op("enc", KEY_A, NONCE_A, AD_A, PT_A, 1'b0, 1'b0);
    @(posedge eph1); #1;
    check_val("enc_pulse_width", {191'd0, encdone}, 192'd0);

    // Decrypt round trip recovers plaintext and the encrypt tag
    run_op("dec", KEY_A, NONCE_A, AD_A, exp_ct, 1'b1, 1'b0);
    check_val("dec_plain", textout, PT_A);
    check_val("dec_tag_eq_enc", {64'd0, authdata}, {64'd0, exp_tag});

    run_op("dec_flip", KEY_A, NONCE_A, AD_A, exp_ct ^ 192'd1, 1'b1, 1'b0);
    check_val("flip_tag_differs", {191'd0, (authdata != exp_tag)}, 192'd1);

    // All-zero operands, then a second start issued in the encdone cycle
    run_op("zero", 128'd0, 128'd0, 128'd0, 192'd0, 1'b0, 1'b0);
    check_val("b2b_done_high", {191'd0, encdone}, 192'd1);
    run_op("zero_b2b", 128'd0, 128'd0, 128'd0, 192'd0, 1'b0, 1'b1);

    // start re-pulsed at cycle 20 with different operands is ignored
    drive(KEY_A, NONCE_A, AD_A, PT_A, 1'b0);
    @(negedge eph1);
    start_now();
    for (int n = 1; n < 20; n++) begin
      @(posedge eph1); #1;
    end
    drive(~KEY_A, ~NONCE_A, ~AD_A, ~PT_A, 1'b1);
    start_now();
    wait_done(20, lat);
    check_val("busy_latency", 192'(lat), 192'(LAT));
    check_val("busy_textout", textout, exp_ct);
    check_val("busy_authdata", {64'd0, authdata}, {64'd0, exp_tag});
    count_pulses(60, pulses);
    check_val("busy_no_restart", 192'(pulses), 192'd0);

    // Reset at cycle 30 aborts the operation
    drive(KEY_A, NONCE_A, AD_A, PT_A, 1'b0);
    @(negedge eph1);
    start_now();
    for (int n = 1; n < 30; n++) begin
      @(posedge eph1); #1;
    end
    reset = 1'b1;
    #1;
    check_val("abort_textout", textout, 192'd0);
    check_val("abort_authdata", {64'd0, authdata}, 192'd0);
    check_val("abort_encdone", {191'd0, encdone}, 192'd0);
    repeat (2) @(posedge eph1);
    @(negedge eph1) reset = 1'b0;
    count_pulses(60, pulses);
    check_val("abort_no_done", 192'(pulses), 192'd0);
    run_op("post_rst", KEY_A, NONCE_A, AD_A, PT_A, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
